// File: rtl/uart_rx_pkg.sv
// Shared constants, CTRL payload and capture-FSM states for the UART RX MMIO window.
package uart_rx_pkg;

  localparam logic [3:0] DATA_OFF   = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] CTRL_OFF   = 4'h8;

  localparam int unsigned ST_NE      = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVR     = 2;
  localparam int unsigned ST_PERR    = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 4;

  localparam int unsigned CTRL_PE      = 0;
  localparam int unsigned CTRL_ODD     = 1;
  localparam int unsigned CTRL_IE      = 2;
  localparam int unsigned CTRL_CLR_ERR = 4;
  localparam int unsigned CTRL_FLUSH   = 5;

  typedef struct packed {
    logic ie;
    logic odd;
    logic pe;
  } ctrl_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    CLEAR    = 2'd2,
    WAIT_LOW = 2'd3
  } rx_state_e;

  // Even parity flags an odd total of ones; odd parity flags an even total.
  function automatic logic parity_err(input logic [8:0] frame, input logic odd);
    return (^frame) ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with flush; guards ignore push when full (unless popping) and pop when empty.
module sync_fifo_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_pop  = pop & ~empty & ~flush;
  assign w_push = push & (~full | w_pop) & ~flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mmio_fifo.sv
// Captures UART RX frames into a FIFO and exposes DATA/STATUS/CTRL registers to the core.
module uart_rx_mmio_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rx_ready,
  input  logic [8:0]  rx_frame,
  output logic        rx_ready_clr,
  input  logic [3:0]  addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  rx_state_e        r_state;
  rx_state_e        w_state_nxt;
  logic             r_rx_ready_clr;
  ctrl_t            r_ctrl;
  logic             r_ovr;
  logic             r_perr;

  logic             w_capture;
  logic             w_rd_data;
  logic             w_ctrl_wr;
  logic             w_flush;
  logic             w_clr_err;
  logic             w_pop;
  logic             w_push;
  logic             w_ovr_set;
  logic             w_perr_set;
  logic [7:0]       w_dout;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_unused_wdata;

  assign w_unused_wdata = &{1'b0, wdata[31:6], wdata[3]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= IDLE;
      r_rx_ready_clr <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rx_ready_clr <= (w_state_nxt == CLEAR);
    end
  end

  // WAIT_LOW holds off re-capture until the receiver has actually dropped ready.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE:     if (rx_ready) w_state_nxt = CAPTURE;
      CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = CLEAR;
      end
      CLEAR:    w_state_nxt = WAIT_LOW;
      WAIT_LOW: if (!rx_ready) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  assign rx_ready_clr = r_rx_ready_clr;

  assign w_rd_data  = re & (addr == DATA_OFF);
  assign w_ctrl_wr  = we & (addr == CTRL_OFF);
  assign w_flush    = w_ctrl_wr & wdata[CTRL_FLUSH];
  assign w_clr_err  = w_ctrl_wr & wdata[CTRL_CLR_ERR];
  assign w_pop      = w_rd_data & ~w_empty;
  assign w_push     = w_capture & ~w_flush;
  assign w_ovr_set  = w_push & w_full & ~w_pop;
  assign w_perr_set = w_capture & r_ctrl.pe & parity_err(rx_frame, r_ctrl.odd);

  sync_fifo_param #(
    .WIDTH (8),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (w_push),
    .din   (rx_frame[7:0]),
    .pop   (w_pop),
    .flush (w_flush),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Sticky flags: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ovr  <= 1'b0;
      r_perr <= 1'b0;
      r_ctrl <= '0;
    end else begin
      if (w_ovr_set)      r_ovr <= 1'b1;
      else if (w_clr_err) r_ovr <= 1'b0;
      if (w_perr_set)     r_perr <= 1'b1;
      else if (w_clr_err) r_perr <= 1'b0;
      if (w_ctrl_wr) begin
        r_ctrl.pe  <= wdata[CTRL_PE];
        r_ctrl.odd <= wdata[CTRL_ODD];
        r_ctrl.ie  <= wdata[CTRL_IE];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      DATA_OFF: begin
        if (!w_empty) rdata[7:0] = w_dout;
      end
      STATUS_OFF: begin
        rdata[ST_NE]   = ~w_empty;
        rdata[ST_FULL] = w_full;
        rdata[ST_OVR]  = r_ovr;
        rdata[ST_PERR] = r_perr;
        rdata[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(w_count);
      end
      CTRL_OFF: begin
        rdata[CTRL_PE]  = r_ctrl.pe;
        rdata[CTRL_ODD] = r_ctrl.odd;
        rdata[CTRL_IE]  = r_ctrl.ie;
      end
      default: rdata = '0;
    endcase
  end

  assign irq = ~w_empty & r_ctrl.ie;

endmodule

// File: tb/tb_uart_rx_mmio_fifo.sv
// Scoreboard bench: expected bytes queued when frames are driven, compared on DATA reads.
module tb_uart_rx_mmio_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        rx_ready;
  logic [8:0]  rx_frame;
  logic        rx_ready_clr;
  logic [3:0]  addr;
  logic        re;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;

  logic [7:0] sb_q[$];
  bit m_ovr, m_perr, m_pe, m_odd, m_ie;

  uart_rx_mmio_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_ready     (rx_ready),
    .rx_frame     (rx_frame),
    .rx_ready_clr (rx_ready_clr),
    .addr         (addr),
    .re           (re),
    .we           (we),
    .wdata        (wdata),
    .rdata        (rdata),
    .irq          (irq)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (rx_ready_clr === 1'b1) clr_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0]   = (sb_q.size() != 0);
    s[1]   = (sb_q.size() == DEPTH);
    s[2]   = m_ovr;
    s[3]   = m_perr;
    s[7:4] = 4'(sb_q.size());
    return s;
  endfunction

  function automatic bit model_perr(input logic [8:0] f);
    return m_pe && (((^f) ^ m_odd) == 1'b1);
  endfunction

  function automatic void model_push(input logic [8:0] f, input bit popping);
    if (sb_q.size() < DEPTH || popping) sb_q.push_back(f[7:0]);
    else m_ovr = 1'b1;
  endfunction

  function automatic void model_ctrl(input logic [31:0] v);
    m_pe  = v[0];
    m_odd = v[1];
    m_ie  = v[2];
    if (v[4]) begin
      m_ovr  = 1'b0;
      m_perr = 1'b0;
    end
    if (v[5]) sb_q.delete();
  endfunction

  function automatic void model_reset();
    sb_q.delete();
    m_ovr = 0; m_perr = 0; m_pe = 0; m_odd = 0; m_ie = 0;
  endfunction

  task automatic read_status(input string tag);
    @(negedge clk);
    addr = 4'h4;
    re   = 1'b1;
    #1;
    check_eq(tag, rdata, exp_status());
    check_eq({tag, "_irq"}, 32'(irq), 32'(m_ie && sb_q.size() != 0));
    re = 1'b0;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] exp;
    @(negedge clk);
    addr = 4'h0;
    re   = 1'b1;
    #1;
    exp = (sb_q.size() != 0) ? {24'h0, sb_q.pop_front()} : 32'h0;
    check_eq(tag, rdata, exp);
    @(posedge clk);
    #1 re = 1'b0;
  endtask

  task automatic write_ctrl(input logic [31:0] v);
    @(negedge clk);
    addr  = 4'h8;
    wdata = v;
    we    = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
    model_ctrl(v);
  endtask

  task automatic wait_clr(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rx_ready_clr === 1'b1) seen = 1;
    end
    check_eq({tag, "_clr_seen"}, 32'(seen), 32'd1);
  endtask

  // Receiver model: hold ready until the clear pulse, then drop it.
  task automatic send_frame(input logic [8:0] f, input string tag);
    int c0;
    bit pe_hit;
    c0 = clr_cnt;
    pe_hit = model_perr(f);
    @(negedge clk);
    rx_frame = f;
    rx_ready = 1'b1;
    wait_clr(tag);
    rx_ready = 1'b0;
    if (pe_hit) m_perr = 1'b1;
    model_push(f, 1'b0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_clr_once"}, 32'(clr_cnt - c0), 32'd1);
  endtask

  // Frame whose CAPTURE cycle coincides with a DATA read (mode 0) or a CTRL write of v (mode 1).
  task automatic frame_with_op(input logic [8:0] f, input bit mode, input logic [31:0] v,
                               input string tag);
    logic [31:0] exp;
    bit pe_hit;
    bit popped;
    pe_hit = model_perr(f);
    popped = 0;
    @(negedge clk);
    rx_frame = f;
    rx_ready = 1'b1;
    @(negedge clk);
    if (mode == 1'b0) begin
      addr = 4'h0;
      re   = 1'b1;
      #1;
      popped = (sb_q.size() != 0);
      exp = popped ? {24'h0, sb_q.pop_front()} : 32'h0;
      check_eq({tag, "_rd"}, rdata, exp);
    end else begin
      addr  = 4'h8;
      wdata = v;
      we    = 1'b1;
    end
    @(posedge clk);
    #1;
    re = 1'b0;
    we = 1'b0;
    if (mode == 1'b1) model_ctrl(v);
    if (!(mode == 1'b1 && v[5])) model_push(f, popped);
    if (pe_hit) m_perr = 1'b1;
    @(negedge clk);
    check_eq({tag, "_clr"}, 32'(rx_ready_clr), 32'd1);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_rst = 1'b0; rx_ready = 1'b0; rx_frame = '0;
    addr = '0; re = 1'b0; we = 1'b0; wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    #1;
    check_eq("rst_clr", 32'(rx_ready_clr), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    read_status("rst_status");
    read_data("rst_data");

    send_frame(9'h041, "f41");
    read_status("one_status");
    read_data("one_data");
    read_status("one_empty");

    for (int i = 0; i < 9; i++) begin
      send_frame(9'(9'h030 + i), "fill");
      if (i == 7) read_status("full_status");
    end
    read_status("ovr_status");
    for (int i = 0; i < 8; i++) read_data("fill_data");
    read_status("drained_status");
    write_ctrl(32'h10);
    read_status("clr_ovr_status");

    write_ctrl(32'h1);
    send_frame(9'h101, "par_ok");
    read_status("par_ok_status");
    send_frame(9'h007, "par_bad");
    read_status("par_bad_status");
    read_data("par_d0");
    read_data("par_d1");
    write_ctrl(32'h11);
    read_status("perr_cleared");

    write_ctrl(32'h3);
    send_frame(9'h003, "odd_bad");
    read_status("odd_bad_status");
    send_frame(9'h103, "odd_ok");
    read_data("odd_d0");
    read_data("odd_d1");
    write_ctrl(32'h10);
    read_status("odd_cleared");

    write_ctrl(32'h4);
    send_frame(9'h0A5, "irq");
    read_status("irq_status");
    read_data("irq_data");
    read_status("irq_empty");

    for (int i = 0; i < 3; i++) read_data("empty_rd");
    frame_with_op(9'h066, 1'b0, 32'h0, "pop_empty");
    read_status("pop_empty_status");
    read_data("pop_empty_data");

    for (int i = 0; i < 8; i++) send_frame(9'(9'h050 + i), "wrapfill");
    frame_with_op(9'h058, 1'b0, 32'h0, "simul");
    read_status("simul_status");
    frame_with_op(9'h059, 1'b0, 32'h0, "simul2");
    read_status("simul2_status");
    for (int i = 0; i < 8; i++) read_data("wrap_data");
    read_status("wrap_empty");

    send_frame(9'h011, "pre_flush0");
    send_frame(9'h012, "pre_flush1");
    frame_with_op(9'h013, 1'b1, 32'h20, "flush");
    read_status("flush_status");

    write_ctrl(32'h1);
    frame_with_op(9'h007, 1'b1, 32'h11, "clr_vs_set");
    read_status("clr_vs_set_status");
    read_data("clr_vs_set_data");
    write_ctrl(32'h14);

    for (int i = 0; i < 3; i++) send_frame(9'(9'h0E0 + i), "pre_rst");
    read_status("pre_rst_status");
    @(negedge clk);
    rx_frame = 9'h0C3;
    rx_ready = 1'b1;
    wait_clr("stuck");
    @(negedge clk);
    n_rst = 1'b0;
    model_reset();
    #1;
    check_eq("midrst_clr", 32'(rx_ready_clr), 32'd0);
    check_eq("midrst_irq", 32'(irq), 32'd0);
    addr = 4'h4;
    #1;
    check_eq("midrst_status", rdata, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    wait_clr("recap");
    rx_ready = 1'b0;
    model_push(9'h0C3, 1'b0);
    repeat (2) @(negedge clk);
    read_status("recap_status");
    check_eq("recap_count", exp_status(), 32'h11);
    read_data("recap_data");
    read_status("recap_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
